// File: rtl/cfeb_lockout_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cfeb_lockout_sched_pkg : shared widths, field slices and FSM encoding      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package cfeb_lockout_sched_pkg;

    localparam int MXCFEB  = 7;
    localparam int MXPATB  = 7;
    localparam int MXKEYB  = 5;
    localparam int MXKEYBX = 8;
    localparam int MXDLYB  = 4;
    localparam int EDGE    = 2;

    // Hit count lives in the top three pattern-id bits
    localparam int HIT_MSB  = MXPATB - 1;
    localparam int HIT_LSB  = MXPATB - 3;
    localparam int CFEB_MSB = MXKEYBX - 1;
    localparam int CFEB_LSB = MXKEYB;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cfeb_lockout_sched_lockout_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cfeb_lockout_sched_lockout_ctr : per-CFEB drift lockout load/down counter  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module cfeb_lockout_sched_lockout_ctr
    import cfeb_lockout_sched_pkg::*;
(
    input  logic              clock,
    input  logic              global_reset_n,
    input  logic              flush,
    input  logic              load,
    input  logic [MXDLYB-1:0] delay,
    output logic              busy
);

    logic [MXDLYB-1:0] r_cnt;

    // Load wins over decrement so a fresh winner restarts the window
    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_cnt <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= delay;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - MXDLYB'(1);
        end
    end

    assign busy = (r_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/cfeb_lockout_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cfeb_lockout_sched : CLCT capture/handshake and CFEB drift lockout control |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module cfeb_lockout_sched
    import cfeb_lockout_sched_pkg::*;
(
    input  logic               clock,
    input  logic               global_reset_n,
    input  logic [MXPATB-1:0]  best_pat,
    input  logic [MXKEYBX-1:0] best_key,
    input  logic               best_bsy,
    input  logic [2:0]         nhit_thresh,
    input  logic [MXDLYB-1:0]  drift_delay,
    input  logic [MXCFEB-1:0]  cfeb_en,
    input  logic               flush,
    output logic [MXCFEB-1:0]  bsy,
    output logic               clct_vld,
    output logic [MXPATB-1:0]  clct_pat,
    output logic [MXKEYBX-1:0] clct_key,
    input  logic               clct_ack,
    output logic [7:0]         drop_cnt,
    output logic               key_err
);

    logic [2:0]         w_cfeb;
    logic [MXKEYB-1:0]  w_hs;
    logic [2:0]         w_hits;
    logic               w_qual;
    logic               w_cfeb_ok;
    logic               w_cand;
    logic               w_lo_edge;
    logic               w_hi_edge;
    logic [MXCFEB-1:0]  w_load;
    logic [MXCFEB-1:0]  w_busy;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_capture;
    logic               w_drop;
    logic [MXPATB-1:0]  r_clct_pat;
    logic [MXKEYBX-1:0] r_clct_key;
    logic [7:0]         r_drop_cnt;
    logic               r_key_err;

    assign w_cfeb    = best_key[CFEB_MSB:CFEB_LSB];
    assign w_hs      = best_key[MXKEYB-1:0];
    assign w_hits    = best_pat[HIT_MSB:HIT_LSB];
    assign w_qual    = !best_bsy && (nhit_thresh != 3'd0) && (w_hits >= nhit_thresh);
    assign w_cfeb_ok = (w_cfeb < 3'(MXCFEB));
    assign w_cand    = w_qual && w_cfeb_ok && !flush;
    assign w_lo_edge = (w_hs < MXKEYB'(EDGE));
    assign w_hi_edge = (w_hs > MXKEYB'(31 - EDGE));

    // Winner's CFEB plus the neighbour on the side the key sits near
    generate
        for (genvar g = 0; g < MXCFEB; g++) begin : g_ctr
            assign w_load[g] = w_cand &&
                ((w_cfeb == 3'(g)) ||
                 (w_lo_edge && (w_cfeb == 3'(g + 1))) ||
                 (w_hi_edge && ((w_cfeb + 3'd1) == 3'(g))));

            cfeb_lockout_sched_lockout_ctr u_ctr (
                .clock          (clock),
                .global_reset_n (global_reset_n),
                .flush          (flush),
                .load           (w_load[g]),
                .delay          (drift_delay),
                .busy           (w_busy[g])
            );
        end
    endgenerate

    assign bsy = w_busy | ~cfeb_en;

    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_drop      = 1'b0;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cand) begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_cand && clct_ack) begin
                        w_capture = 1'b1;
                    end else if (w_cand) begin
                        w_drop = 1'b1;
                    end else if (clct_ack) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // drop_cnt deliberately survives flush; only reset clears it
    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_clct_pat <= '0;
            r_clct_key <= '0;
            r_drop_cnt <= '0;
            r_key_err  <= 1'b0;
        end else begin
            r_key_err <= w_qual && !w_cfeb_ok;
            if (w_capture) begin
                r_clct_pat <= best_pat;
                r_clct_key <= best_key;
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign clct_vld = (r_state == ST_HOLD);
    assign clct_pat = r_clct_pat;
    assign clct_key = r_clct_key;
    assign drop_cnt = r_drop_cnt;
    assign key_err  = r_key_err;

endmodule
`default_nettype wire
